// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 responder: holds STATUS/CAUSE/EPC, arbitrates syscall traps against
// external interrupts and issues a registered one-cycle redirect+flush to fetch.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0800,
  parameter int          IRQ_W      = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      pc_i,
  input  logic             syscall_i,
  input  logic             eret_i,
  input  logic             mtc0_i,
  input  logic             mfc0_i,
  input  logic [4:0]       cp0_addr_i,
  input  logic [31:0]      cp0_wdata_i,
  input  logic [IRQ_W-1:0] irq_i,
  output logic [31:0]      cp0_rdata_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic             exl_o,
  output logic [31:0]      epc_o
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYS     = 5'd8;

  typedef enum logic {S_RUN, S_REDIR} state_e;

  state_e           state_q;
  logic             ie_q, exl_q;
  logic [IRQ_W-1:0] im_q, ip_q;
  logic [4:0]       exc_code_q;
  logic [31:0]      epc_q, redirect_pc_q;
  logic             redirect_valid_q;

  logic        int_pend, accept;
  logic        take_sys, take_eret, take_int, take_mtc0;
  logic [31:0] epc_sys_d;
  logic [31:0] status_w, cause_w;

  assign int_pend  = ie_q & ~exl_q & (|(ip_q & im_q));
  assign accept    = instr_valid_i & (state_q == S_RUN);
  assign take_sys  = accept & syscall_i;
  assign take_eret = accept & ~syscall_i & eret_i;
  assign take_int  = accept & ~syscall_i & ~eret_i & int_pend;
  assign take_mtc0 = accept & ~syscall_i & ~eret_i & ~int_pend & mtc0_i;
  assign epc_sys_d = pc_i + 32'd4;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q          <= S_RUN;
      ie_q             <= 1'b0;
      exl_q            <= 1'b0;
      im_q             <= '0;
      ip_q             <= '0;
      exc_code_q       <= '0;
      epc_q            <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
    end else begin
      ip_q             <= irq_i;
      redirect_valid_q <= 1'b0;
      if (state_q == S_REDIR) begin
        state_q <= S_RUN;
      end else if (take_sys) begin
        epc_q            <= epc_sys_d;
        exc_code_q       <= EXC_SYS;
        exl_q            <= 1'b1;
        redirect_pc_q    <= EXC_VECTOR;
        redirect_valid_q <= 1'b1;
        state_q          <= S_REDIR;
      end else if (take_eret) begin
        exl_q            <= 1'b0;
        redirect_pc_q    <= epc_q;
        redirect_valid_q <= 1'b1;
        state_q          <= S_REDIR;
      end else if (take_int) begin
        // Interrupted instruction is not executed, so it restarts at its own PC.
        epc_q            <= pc_i;
        exc_code_q       <= EXC_INT;
        exl_q            <= 1'b1;
        redirect_pc_q    <= EXC_VECTOR;
        redirect_valid_q <= 1'b1;
        state_q          <= S_REDIR;
      end else if (take_mtc0) begin
        if (cp0_addr_i == ADDR_STATUS) begin
          ie_q  <= cp0_wdata_i[0];
          exl_q <= cp0_wdata_i[1];
          im_q  <= cp0_wdata_i[8 +: IRQ_W];
        end else if (cp0_addr_i == ADDR_EPC) begin
          epc_q <= cp0_wdata_i;
        end
      end
    end
  end

  always_comb begin
    status_w              = '0;
    status_w[0]           = ie_q;
    status_w[1]           = exl_q;
    status_w[8 +: IRQ_W]  = im_q;
    cause_w               = '0;
    cause_w[6:2]          = exc_code_q;
    cause_w[8 +: IRQ_W]   = ip_q;
    cp0_rdata_o           = '0;
    if (mfc0_i) begin
      case (cp0_addr_i)
        ADDR_STATUS: cp0_rdata_o = status_w;
        ADDR_CAUSE:  cp0_rdata_o = cause_w;
        ADDR_EPC:    cp0_rdata_o = epc_q;
        default:     cp0_rdata_o = '0;
      endcase
    end
  end

  // Reset asserted during the redirect cycle suppresses the pulse already in flight.
  assign redirect_valid_o = redirect_valid_q & rst_n_i;
  assign flush_o          = redirect_valid_o;
  assign redirect_pc_o    = redirect_pc_q;
  assign exl_o            = exl_q;
  assign epc_o            = epc_q;

endmodule
